// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, fetch FSM states and PC select codes.
// Imported by the fetch unit and its helpers.
package cpu_pkg;

    localparam int ADDR_W  = 19;
    localparam int INSTR_W = 19;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DROP = 3'd4,
        S_ERR  = 3'd5
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_BR  = 2'b01,
        PC_JMP = 2'b10,
        PC_RET = 2'b11
    } pc_sel_e;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Response-wait counter for the fetch unit.
// Saturates at TIMEOUT-1 so expired stays asserted once reached.
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Baseline single-outstanding instruction fetcher between PC and decode.
// Issues one memory read per instruction and holds the result for decode.
module instr_fetch_unit #(
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  pc,
    input  logic               flush,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               pc_advance,
    output logic               fetch_err
);

    import cpu_pkg::*;

    fetch_state_e state_q, state_d;

    logic ctr_clear;
    logic ctr_en;
    logic expired;
    logic latch_addr;
    logic latch_instr;
    logic set_err;

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (ctr_clear),
        .enable  (ctr_en),
        .expired (expired)
    );

    always_comb begin
        state_d     = state_q;
        ctr_clear   = 1'b0;
        ctr_en      = 1'b0;
        latch_addr  = 1'b0;
        latch_instr = 1'b0;
        set_err     = 1'b0;
        mem_req     = 1'b0;
        instr_valid = 1'b0;
        pc_advance  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!flush) begin
                    latch_addr = 1'b1;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    // a granted request always owes a response
                    ctr_clear = 1'b1;
                    state_d   = flush ? S_DROP : S_WAIT;
                end else if (flush) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                ctr_en = 1'b1;
                if (mem_rvalid) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        latch_instr = 1'b1;
                        state_d     = S_HOLD;
                    end
                end else if (expired) begin
                    set_err = 1'b1;
                    state_d = S_ERR;
                end else if (flush) begin
                    state_d = S_DROP;
                end
            end
            S_HOLD: begin
                instr_valid = 1'b1;
                if (flush) begin
                    state_d = S_IDLE;
                end else if (instr_ready) begin
                    pc_advance = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            S_DROP: begin
                ctr_en = 1'b1;
                if (mem_rvalid) begin
                    state_d = S_IDLE;
                end else if (expired) begin
                    set_err = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mem_addr  <= '0;
            instr     <= '0;
            instr_pc  <= '0;
            fetch_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch_addr) begin
                mem_addr <= pc;
            end
            if (latch_instr) begin
                instr    <= mem_rdata;
                instr_pc <= mem_addr;
            end
            if (set_err) begin
                fetch_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized checks for instr_fetch_unit.
// Reference: a program-order model of pc plus a simple memory responder.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [18:0] pc;
    logic        flush;
    logic        mem_req;
    logic [18:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [18:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [18:0] instr;
    logic [18:0] instr_pc;
    logic        pc_advance;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;
    int accepted = 0;

    logic [18:0] mpc;
    logic [18:0] nxt;
    logic [18:0] tgt;
    logic [18:0] oaddr;
    logic [18:0] a;
    logic        owed;
    logic        g;
    logic        r;
    int          lat;

    instr_fetch_unit #(
        .ADDR_W  (19),
        .INSTR_W (19),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc          (pc),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .pc_advance  (pc_advance),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] memfn(input logic [18:0] ad);
        return (ad ^ 19'h5A3C1) + {ad[6:0], ad[18:7]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_to_hold(input logic [18:0] d);
        go();
        mem_gnt = 1'b1;
        go();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        go();
        mem_rvalid = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        pc          = 19'h00010;
        flush       = 1'b0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        instr_ready = 1'b0;
        owed        = 1'b0;
        lat         = 0;
        tgt         = '0;
        oaddr       = '0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_ipc", instr_pc, 0);
        check("rst_adv", pc_advance, 0);
        check("rst_err", fetch_err, 0);

        // zero-wait fetch
        @(posedge clk);
        #1 rst_n = 1'b1;
        go();
        mem_gnt = 1'b1;
        @(negedge clk);
        check("z_req", mem_req, 1);
        check("z_addr", mem_addr, 19'h00010);
        go();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 19'h4A5A5;
        @(negedge clk);
        check("z_req_off", mem_req, 0);
        check("z_valid_early", instr_valid, 0);
        go();
        mem_rvalid  = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        check("z_valid", instr_valid, 1);
        check("z_instr", instr, 19'h4A5A5);
        check("z_ipc", instr_pc, 19'h00010);
        check("z_adv", pc_advance, 1);
        go();
        pc          = 19'h00011;
        instr_ready = 1'b0;
        @(negedge clk);
        check("z_adv_once", pc_advance, 0);
        check("z_valid_off", instr_valid, 0);

        // backpressure
        fetch_to_hold(19'h2B3C4);
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", instr_valid, 1);
            check("bp_instr", instr, 19'h2B3C4);
            check("bp_ipc", instr_pc, 19'h00011);
            check("bp_no_adv", pc_advance, 0);
            go();
        end
        instr_ready = 1'b1;
        @(negedge clk);
        check("bp_adv", pc_advance, 1);
        go();
        instr_ready = 1'b0;
        pc          = 19'h00012;
        @(negedge clk);
        check("bp_adv_once", pc_advance, 0);
        check("bp_valid_off", instr_valid, 0);

        // flush in WAIT, late response dropped
        go();
        mem_gnt = 1'b1;
        go();
        mem_gnt = 1'b0;
        flush   = 1'b1;
        @(negedge clk);
        check("fw_valid0", instr_valid, 0);
        go();
        flush = 1'b0;
        pc    = 19'h01234;
        @(negedge clk);
        check("fw_req_drop", mem_req, 0);
        check("fw_valid1", instr_valid, 0);
        go();
        @(negedge clk);
        check("fw_req_drop2", mem_req, 0);
        go();
        mem_rvalid = 1'b1;
        mem_rdata  = 19'h7FFFF;
        @(negedge clk);
        check("fw_valid2", instr_valid, 0);
        check("fw_adv", pc_advance, 0);
        go();
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("fw_valid3", instr_valid, 0);
        check("fw_req_idle", mem_req, 0);
        go();
        mem_gnt = 1'b1;
        @(negedge clk);
        check("fw_req", mem_req, 1);
        check("fw_addr", mem_addr, 19'h01234);

        // flush and ready together in HOLD
        go();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 19'h0F00D;
        go();
        mem_rvalid  = 1'b0;
        flush       = 1'b1;
        instr_ready = 1'b1;
        @(negedge clk);
        check("fh_valid", instr_valid, 1);
        check("fh_instr", instr, 19'h0F00D);
        check("fh_ipc", instr_pc, 19'h01234);
        check("fh_no_adv", pc_advance, 0);
        go();
        flush       = 1'b0;
        instr_ready = 1'b0;
        pc          = 19'h00800;
        @(negedge clk);
        check("fh_valid_off", instr_valid, 0);
        check("fh_idle_req", mem_req, 0);
        go();
        @(negedge clk);
        check("fh_req", mem_req, 1);
        check("fh_addr", mem_addr, 19'h00800);

        // async reset mid-WAIT
        mem_gnt = 1'b1;
        go();
        mem_gnt = 1'b0;
        go();
        #3 rst_n = 1'b0;
        #1;
        check("ar_req", mem_req, 0);
        check("ar_addr", mem_addr, 0);
        check("ar_valid", instr_valid, 0);
        check("ar_instr", instr, 0);
        check("ar_ipc", instr_pc, 0);
        check("ar_adv", pc_advance, 0);
        check("ar_err", fetch_err, 0);
        go();
        pc         = 19'h00ABC;
        mem_rvalid = 1'b1;
        mem_rdata  = 19'h12345;
        rst_n      = 1'b1;
        @(negedge clk);
        check("ar_stray_valid", instr_valid, 0);
        check("ar_stray_req", mem_req, 0);
        go();
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("ar_fresh_req", mem_req, 1);
        check("ar_fresh_addr", mem_addr, 19'h00ABC);
        check("ar_instr_kept", instr, 0);

        // timeout after 8 WAIT cycles
        mem_gnt = 1'b1;
        go();
        mem_gnt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("to_err_low", fetch_err, 0);
            check("to_req_low", mem_req, 0);
            go();
        end
        @(negedge clk);
        check("to_err", fetch_err, 1);
        check("to_req", mem_req, 0);
        check("to_valid", instr_valid, 0);
        go();
        flush       = 1'b1;
        mem_rvalid  = 1'b1;
        instr_ready = 1'b1;
        repeat (3) go();
        @(negedge clk);
        check("to_err_sticky", fetch_err, 1);
        check("to_req_sticky", mem_req, 0);
        check("to_valid_sticky", instr_valid, 0);
        check("to_adv_sticky", pc_advance, 0);
        flush       = 1'b0;
        mem_rvalid  = 1'b0;
        instr_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("to_err_clr", fetch_err, 0);

        // randomized traffic against the program-order model
        go();
        mpc   = 19'($urandom);
        pc    = mpc;
        rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (mem_req) begin
                check("r_addr", mem_addr, mpc);
                check("r_single", owed, 0);
            end
            if (pc_advance) begin
                check("r_adv_flush", flush, 0);
                check("r_ipc", instr_pc, mpc);
                check("r_instr", instr, memfn(mpc));
                accepted++;
            end
            if (c % 100 == 0) begin
                check("r_err", fetch_err, 0);
            end
            g = mem_req && mem_gnt;
            r = mem_rvalid;
            a = mem_addr;
            if (flush) begin
                nxt = tgt;
            end else if (pc_advance) begin
                nxt = mpc + 19'd1;
            end else begin
                nxt = mpc;
            end
            go();
            if (r) begin
                owed = 1'b0;
            end
            if (g) begin
                owed  = 1'b1;
                oaddr = a;
                lat   = int'($urandom_range(0, 3));
            end
            mpc         = nxt;
            pc          = mpc;
            flush       = ($urandom_range(0, 15) == 0);
            tgt         = 19'($urandom);
            instr_ready = ($urandom_range(0, 2) != 0);
            mem_gnt     = mem_req && ($urandom_range(0, 1) == 1);
            if (owed && lat == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = memfn(oaddr);
            end else begin
                if (owed) begin
                    lat--;
                end
                mem_rvalid = 1'b0;
                mem_rdata  = 19'($urandom);
            end
        end
        check("r_progress", accepted >= 50, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
